// File: rtl/slide_cmd_sequencer.sv
// slide_cmd_sequencer: turns two signed-digit windows into a DBL/ADD/SUB command stream
// for the double-scalar multiplier, with a valid/ready command port.
module slide_cmd_sequencer #(
  parameter int N_DIGITS = 256,
  parameter int DIGIT_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_DIGITS*DIGIT_W-1:0]  a_digits,
  input  logic [N_DIGITS*DIGIT_W-1:0]  b_digits,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [1:0]                   cmd_op,
  output logic                         cmd_sel,
  output logic [2:0]                   cmd_idx,
  output logic [7:0]                   cmd_pos,
  output logic                         cmd_last,
  output logic [9:0]                   cmd_count,
  output logic                         digit_err,
  output logic                         busy,
  output logic                         done
);
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DBL, S_A, S_B, S_DONE} state_t;
  state_t r_state, w_ns, w_adv;
  logic [7:0] r_i, w_ni, w_adv_i;
  logic [N_DIGITS*DIGIT_W-1:0] r_a, r_b;
  logic [DIGIT_W-1:0] w_da, w_db, w_na, w_nb, w_nd;
  logic w_acc, w_ill, w_last, w_start, w_emit;
  assign w_acc   = cmd_valid & cmd_ready;
  assign w_start = (r_state == S_IDLE) & start;
  assign w_da    = r_a[r_i*DIGIT_W +: DIGIT_W];
  assign w_db    = r_b[r_i*DIGIT_W +: DIGIT_W];
  assign w_na    = r_a[w_ni*DIGIT_W +: DIGIT_W];
  assign w_nb    = r_b[w_ni*DIGIT_W +: DIGIT_W];
  assign w_nd    = (w_ns == S_B) ? w_nb : w_na;
  // odd 5-bit values are exactly the legal non-zero digits; non-zero even ones are errors
  assign w_ill   = (w_da != '0 && !w_da[0]) || (w_db != '0 && !w_db[0]);
  assign w_emit  = (w_ns == S_A) || (w_ns == S_B);
  assign w_adv   = (r_i == 8'd0) ? S_DONE : S_DBL;
  assign w_adv_i = (r_i == 8'd0) ? r_i : r_i - 8'd1;
  assign w_last  = (w_ni == 8'd0) && ((w_ns == S_DBL) ? !(w_na[0] | w_nb[0]) :
                                      (w_ns == S_A) ? !w_nb[0] : (w_ns == S_B));
  always_comb begin
    w_ns = r_state;
    w_ni = r_i;
    case (r_state)
      S_IDLE: if (start) begin
        w_ns = S_SCAN;
        w_ni = 8'(N_DIGITS - 1);
      end
      S_SCAN: begin
        w_ns = (w_da != '0 || w_db != '0) ? S_DBL : (r_i == 8'd0) ? S_DONE : S_SCAN;
        w_ni = (w_da != '0 || w_db != '0 || r_i == 8'd0) ? r_i : r_i - 8'd1;
      end
      S_DBL: if (w_acc) begin
        w_ns = w_da[0] ? S_A : (w_db[0] ? S_B : w_adv);
        w_ni = (w_da[0] | w_db[0]) ? r_i : w_adv_i;
      end
      S_A: if (w_acc) begin
        w_ns = w_db[0] ? S_B : w_adv;
        w_ni = w_db[0] ? r_i : w_adv_i;
      end
      S_B: if (w_acc) begin
        w_ns = w_adv;
        w_ni = w_adv_i;
      end
      default: w_ns = S_IDLE;
    endcase
  end
  // outputs are computed from the next state so the command port is fully registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_i       <= 8'd255;
      cmd_valid <= 1'b0;
      cmd_op    <= 2'd0;
      cmd_sel   <= 1'b0;
      cmd_idx   <= 3'd0;
      cmd_pos   <= 8'd0;
      cmd_last  <= 1'b0;
      cmd_count <= 10'd0;
      digit_err <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_ns;
      r_i       <= w_ni;
      cmd_valid <= (w_ns == S_DBL) || w_emit;
      cmd_op    <= w_emit ? (w_nd[DIGIT_W-1] ? 2'd2 : 2'd1) : 2'd0;
      cmd_sel   <= (w_ns == S_B);
      cmd_idx   <= w_emit ? 3'((w_nd[DIGIT_W-1] ? -w_nd : w_nd) >> 1) : 3'd0;
      cmd_pos   <= w_ni;
      cmd_last  <= w_last;
      cmd_count <= w_start ? 10'd0 : cmd_count + 10'(w_acc);
      digit_err <= w_start ? 1'b0 : digit_err | ((r_state == S_DBL) & w_ill);
      busy      <= (w_ns != S_IDLE);
      done      <= (w_ns == S_DONE);
    end
  end
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_a <= a_digits;
      r_b <= b_digits;
    end
  end
endmodule

// File: tb/tb_slide_cmd_sequencer.sv
// tb_slide_cmd_sequencer: scoreboard bench; a digit-level reference model fills the
// expected queue, a monitor pops and compares on every accepted command.
module tb_slide_cmd_sequencer;
  typedef struct packed {
    logic [1:0] op;
    logic       sel;
    logic [2:0] idx;
    logic [7:0] pos;
    logic       last;
  } cmd_t;
  logic clk = 0, rst = 1, start = 0, cmd_ready = 1;
  logic [1279:0] a_digits = '0, b_digits = '0;
  logic cmd_valid, cmd_sel, cmd_last, digit_err, busy, done;
  logic [1:0] cmd_op;
  logic [2:0] cmd_idx;
  logic [7:0] cmd_pos;
  logic [9:0] cmd_count;
  cmd_t got, prev;
  assign got = {cmd_op, cmd_sel, cmd_idx, cmd_pos, cmd_last};
  slide_cmd_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .a_digits(a_digits), .b_digits(b_digits),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_idx(cmd_idx), .cmd_pos(cmd_pos), .cmd_last(cmd_last), .cmd_count(cmd_count),
    .digit_err(digit_err), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0;
  cmd_t exp_q[$];
  int a[256], b[256];
  int t0 = 0, first_seen = -1, top_exp, n_exp;
  bit err_exp, rnd_ready = 0, hold_b = 0, stalled = 0;
  int stall_left = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic bit legal(input int d);
    return (d % 2 != 0) && d >= -15 && d <= 15;
  endfunction
  function automatic cmd_t mk(input int op, input int sel, input int d, input int p);
    cmd_t c;
    c.op = 2'(op); c.sel = 1'(sel); c.idx = 3'((d < 0 ? -d : d) / 2); c.pos = 8'(p); c.last = 0;
    return c;
  endfunction
  // reference: walk positions top-down from the highest non-zero one
  task automatic build();
    top_exp = -1; err_exp = 0;
    exp_q.delete();
    for (int p = 0; p < 256; p++) begin
      a_digits[p*5 +: 5] = 5'(a[p]);
      b_digits[p*5 +: 5] = 5'(b[p]);
      if (a[p] != 0 || b[p] != 0) top_exp = p;
      if ((a[p] != 0 && !legal(a[p])) || (b[p] != 0 && !legal(b[p]))) err_exp = 1;
    end
    for (int p = top_exp; p >= 0; p--) begin
      exp_q.push_back(mk(0, 0, 0, p));
      if (legal(a[p])) exp_q.push_back(mk(a[p] > 0 ? 1 : 2, 0, a[p], p));
      if (legal(b[p])) exp_q.push_back(mk(b[p] > 0 ? 1 : 2, 1, b[p], p));
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1;
    n_exp = exp_q.size();
  endtask
  task automatic clr();
    for (int p = 0; p < 256; p++) begin a[p] = 0; b[p] = 0; end
  endtask
  task automatic kick();
    @(posedge clk); #1 start = 1; t0 = cyc; first_seen = -1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic run(input bit timed, input int stall);
    build();
    kick();
    for (int k = 0; k < 4000 && !done; k++) @(negedge clk);
    chk("done_seen", done, 1);
    chk("first_valid", first_seen, top_exp < 0 ? -1 : 257 - top_exp);
    if (timed) chk("done_cycle", cyc - t0, top_exp < 0 ? 257 : 257 - top_exp + n_exp + stall);
    chk("cmd_count", cmd_count, n_exp);
    chk("digit_err", digit_err, err_exp);
    chk("queue_left", exp_q.size(), 0);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
  endtask
  function automatic int rnd_digit();
    int d;
    if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 1) ? -16 : 2 * int'($urandom_range(1, 7));
    else d = 2 * int'($urandom_range(0, 7)) + 1;
    return $urandom_range(0, 1) ? -d : d;
  endfunction
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && cmd_valid && cmd_op == 2'd2) begin
      cmd_ready = 0; stall_left--;
    end else if (hold_b && cmd_valid && cmd_sel) cmd_ready = 0;
    else cmd_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  initial forever begin
    @(negedge clk);
    if (rst) stalled = 0;
    else begin
      if (stalled) begin
        chk("hold_valid", cmd_valid, 1);
        chk("hold_payload", got, prev);
      end
      if (cmd_valid) begin
        if (first_seen < 0) first_seen = cyc - t0;
        if (cmd_ready) begin
          if (exp_q.size() == 0) chk("extra_cmd", 0, 1);
          else chk("cmd", got, exp_q.pop_front());
        end
      end
      stalled = cmd_valid && !cmd_ready;
      prev = got;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_err", digit_err, 0);
    chk("rst_payload", got, 0);
    @(negedge clk) rst = 0;
    clr(); run(1, 0);
    clr(); a[0] = 1; run(1, 0);
    clr(); a[3] = -5; b[3] = 15; run(1, 0);
    stall_left = 5; run(1, 5);
    clr(); a[7] = 4; b[7] = -16; run(1, 0);
    clr(); a[3] = -5; b[3] = 15; hold_b = 1;
    build(); kick();
    for (int k = 0; k < 400 && !(cmd_valid && cmd_sel); k++) @(negedge clk);
    chk("reached_b", cmd_valid & cmd_sel, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_valid", cmd_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_q.delete(); hold_b = 0;
    @(negedge clk) rst = 0;
    clr(); a[0] = 1; run(1, 0);
    rnd_ready = 1;
    for (int r = 0; r < 6; r++) begin
      int top;
      clr();
      top = $urandom_range(0, 255);
      for (int p = 0; p <= top; p++) begin
        if ($urandom_range(0, 3) == 0) a[p] = rnd_digit();
        if ($urandom_range(0, 3) == 0) b[p] = rnd_digit();
      end
      if (a[top] == 0 && b[top] == 0) a[top] = 1;
      run(0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/slide_cmd_sequencer.md
Name: slide_cmd_sequencer

Overview:
Consumes two signed-digit windows produced by the sliding-window recoder, one for scalar a and one for scalar b. It emits the point-operation command stream for the Ed25519 double-scalar multiplication engine. The block first scans from the top position down and skips positions where both digits are zero. From the first non-zero position down to 0 it issues one DOUBLE per position, then ADD or SUB with a precomputed-table index for each non-zero digit. It sits between the recoder and the point-arithmetic unit, which accepts commands over a valid/ready handshake.

Parameters:
N_DIGITS, 256, number of digit positions per scalar.
DIGIT_W, 5, signed digit width in two's complement (-16..15).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; sampled only in IDLE
a_digits  in  N_DIGITS*DIGIT_W  digit i of scalar a at bits [5i+4:5i]
b_digits  in  N_DIGITS*DIGIT_W  digit i of scalar b, same packing
cmd_valid  out  1  command present
cmd_ready  in  1  downstream accepts command
cmd_op  out  2  0=DBL, 1=ADD, 2=SUB (3 never driven)
cmd_sel  out  1  0=table A, 1=table B (0 for DBL)
cmd_idx  out  3  table index = |digit|>>1 (0 for DBL)
cmd_pos  out  8  digit position of the command
cmd_last  out  1  final command of the stream
cmd_count  out  10  commands accepted in the current or last run
digit_err  out  1  sticky; illegal digit seen in the current or last run
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at the end of a run

Behaviour:
- Reset (async, rst=1): state=IDLE; i=255; all outputs 0; the latched digit arrays are not cleared.
- IDLE, start=1: latch a_digits and b_digits, set i=255, clear cmd_count and digit_err, go to SCAN. start is ignored in every other state.
- SCAN (one position per cycle):
  - If a[i]!=0 or b[i]!=0: go to EMIT_DBL.
  - Else if i==0: go to DONE.
  - Else: i<=i-1.
- EMIT_DBL: cmd_valid=1, op=DBL, pos=i. On accept, next state is the first applicable of: EMIT_A if a[i] is legal and non-zero; else EMIT_B if b[i] is legal and non-zero; else ADVANCE.
- EMIT_A and EMIT_B:
  - op=ADD if the digit is positive, SUB if negative.
  - sel=0 for EMIT_A, 1 for EMIT_B; idx=|d|>>1; pos=i.
  - EMIT_A on accept goes to EMIT_B if b[i] is legal and non-zero, else ADVANCE.
  - EMIT_B on accept goes to ADVANCE.
- ADVANCE is implemented inside the accept transition, so there is no bubble cycle:
  - If i==0: go to DONE.
  - Else: i<=i-1 and go to EMIT_DBL.
  - After the first non-zero position, every lower position gets a DBL even when both digits are zero.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle done falls.
- Legal digit: odd, in -15..15. A non-zero illegal digit (even, or -16):
  - sets digit_err;
  - emits no ADD/SUB for that digit;
  - still counts as non-zero for SCAN termination.
- Handshake:
  - cmd_valid and the payload are registered.
  - The payload is held stable while cmd_valid=1 and cmd_ready=0.
  - A transfer occurs when cmd_valid and cmd_ready are both high.
  - cmd_valid never drops without a transfer, except on reset.
  - cmd_ready is ignored when cmd_valid=0.
- cmd_last is high with the last command of position 0.
- cmd_count increments on each transfer. Maximum is 768, so no overflow.
- Latency with cmd_ready=1:
  - start is sampled at cycle 0; SCAN begins at cycle 1.
  - The first cmd_valid appears at cycle 2+(255-t), where t is the highest non-zero position.
  - After that, one command transfers per cycle.
- All-zero inputs: SCAN runs cycles 1..256, done is at cycle 257, and no command is issued.
- Reset mid-run: immediate abort, cmd_valid=0, return to IDLE. A partially issued stream is not resumed. After rst falls, a new start works normally.

Test Plan:
- All digits zero, start at cycle 0 -> no cmd_valid; done=1 at cycle 257; cmd_count=0; digit_err=0.
- a[0]=+1, everything else zero, cmd_ready=1 -> DBL pos0 at cycle 257, then ADD sel0 idx0 pos0 with last=1; cmd_count=2.
- a[3]=-5, b[3]=+15, everything else zero, cmd_ready=1 -> first cmd_valid at cycle 254, then in order: DBL p3; SUB A idx2 p3; ADD B idx7 p3; DBL p2; DBL p1; DBL p0 with last=1; cmd_count=6.
- Same stimulus with cmd_ready low for 5 cycles during the SUB command -> the SUB payload is stable for all 5 cycles; the sequence is identical with no drop or duplicate; done is 5 cycles later.
- a[7]=+4, b[7]=-16, everything else zero -> digit_err=1; DBL p7..p0 only (8 commands, no ADD/SUB); last on p0.
- rst pulsed while an EMIT_B command is stalled -> cmd_valid=0, busy=0, done=0 asynchronously; a new start with a[0]=+1 produces the exact stream of the second scenario.
